// File: rtl/ascon_perm_seq.sv
// ascon_perm_seq: sequential Ascon permutation round controller around asconp, UROL rounds per clock.
// Optional `ASCON_PERM_SEQ_ZEROIZE_EN clears the state register on the output handshake.
module asconp #(
  parameter int UROL = 1
) (
  input  logic [3:0]  round_cnt,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);
  typedef logic [0:4][63:0] st_t;
  st_t s;
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  // One Ascon round for round index i; constant {15-i, i} is {~i, i} in 4 bits.
  function automatic st_t rnd(input st_t si, input logic [3:0] i);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    a0 = si[0];
    a1 = si[1];
    a2 = si[2] ^ {56'd0, ~i, i};
    a3 = si[3];
    a4 = si[4];
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    return {a0 ^ ror(a0, 19) ^ ror(a0, 28), a1 ^ ror(a1, 61) ^ ror(a1, 39),
            a2 ^ ror(a2, 1) ^ ror(a2, 6), a3 ^ ror(a3, 10) ^ ror(a3, 17),
            a4 ^ ror(a4, 7) ^ ror(a4, 41)};
  endfunction
  always_comb begin
    s = {x0_i, x1_i, x2_i, x3_i, x4_i};
    for (int r = 0; r < UROL; r++) s = rnd(s, 4'(12 - int'(round_cnt) + r));
  end
  assign {x0_o, x1_o, x2_o, x3_o, x4_o} = s;
endmodule

module ascon_perm_seq #(
  parameter int UROL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st;
  logic [3:0] rcnt;
  logic [63:0] p0, p1, p2, p3, p4;
  logic legal;
  assign legal = rounds_i == 4'd6 || rounds_i == 4'd8 || rounds_i == 4'd12;
  asconp #(.UROL(UROL)) u_p (
    .round_cnt(rcnt),
    .x0_i(x0_o), .x1_i(x1_o), .x2_i(x2_o), .x3_i(x3_o), .x4_i(x4_o),
    .x0_o(p0), .x1_o(p1), .x2_o(p2), .x3_o(p3), .x4_o(p4)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      rcnt <= '0;
      {x0_o, x1_o, x2_o, x3_o, x4_o} <= '0;
      ready_o <= 1'b1;
      busy_o <= 1'b0;
      out_valid_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (st)
        IDLE: if (start_i) begin
          if (legal) begin
            st <= RUN;
            rcnt <= rounds_i;
            {x0_o, x1_o, x2_o, x3_o, x4_o} <= {x0_i, x1_i, x2_i, x3_i, x4_i};
            ready_o <= 1'b0;
            busy_o <= 1'b1;
          end else err_o <= 1'b1;
        end
        RUN: begin
          {x0_o, x1_o, x2_o, x3_o, x4_o} <= {p0, p1, p2, p3, p4};
          rcnt <= rcnt - 4'(UROL);
          if (rcnt == 4'(UROL)) begin
            st <= DONE;
            busy_o <= 1'b0;
            out_valid_o <= 1'b1;
          end
        end
        DONE: if (out_ready_i) begin
          st <= IDLE;
          out_valid_o <= 1'b0;
          ready_o <= 1'b1;
`ifdef ASCON_PERM_SEQ_ZEROIZE_EN
          {x0_o, x1_o, x2_o, x3_o, x4_o} <= '0;
`endif
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_perm_seq.sv
// tb_ascon_perm_seq: scoreboard bench driving a UROL=1 and a UROL=2 instance with shared stimulus,
// checked against an S-box-table reference model of the Ascon permutation.
module tb_ascon_perm_seq;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, out_ready_i = 1'b1;
  logic [3:0] rounds_i = '0;
  logic [63:0] x0_i = '0, x1_i = '0, x2_i = '0, x3_i = '0, x4_i = '0;
  logic r1, bs1, e1, v1, r2, bs2, e2, v2;
  logic [63:0] a0, a1, a2, a3, a4, b0, b1, b2, b3, b4;
  logic [319:0] ya, yb;
  assign ya = {a0, a1, a2, a3, a4};
  assign yb = {b0, b1, b2, b3, b4};

  ascon_perm_seq #(.UROL(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start_i), .rounds_i(rounds_i),
    .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
    .ready_o(r1), .busy_o(bs1), .err_o(e1), .out_valid_o(v1), .out_ready_i(out_ready_i),
    .x0_o(a0), .x1_o(a1), .x2_o(a2), .x3_o(a3), .x4_o(a4)
  );
  ascon_perm_seq #(.UROL(2)) u2 (
    .clk(clk), .rst(rst), .start_i(start_i), .rounds_i(rounds_i),
    .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
    .ready_o(r2), .busy_o(bs2), .err_o(e2), .out_valid_o(v2), .out_ready_i(out_ready_i),
    .x0_o(b0), .x1_o(b1), .x2_o(b2), .x3_o(b3), .x4_o(b4)
  );

  always #5 clk = ~clk;

`ifdef ASCON_PERM_SEQ_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  typedef struct {
    logic [319:0] s;
    int t;
    int lat;
  } exp_t;
  exp_t q1[$], q2[$];
  exp_t e;
  int cyc = 0, errors = 0, checks = 0;
  bit rbp = 1'b0;
  logic pv1 = 1'b0, pv2 = 1'b0, hs1 = 1'b0, hs2 = 1'b0;
  logic [319:0] last1 = '0, last2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Column-wise S-box lookup, rounds indexed 12-n .. 11 as in p12.
  function automatic logic [319:0] model(input logic [319:0] s, input int n);
    logic [63:0] x[5];
    logic [4:0] v;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64 * k -: 64];
    for (int r = 12 - n; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        x[0][b] = v[4];
        x[1][b] = v[3];
        x[2][b] = v[2];
        x[3][b] = v[1];
        x[4][b] = v[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1) ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7) ^ ror(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [319:0] rnd_state();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    hs1 <= !rst && v1 && out_ready_i;
    hs2 <= !rst && v2 && out_ready_i;
  end

  // Monitor: result checked on each rising out_valid, post-handshake state checked a cycle later.
  always @(negedge clk) begin
    if (!rst) begin
      if (hs1) chk("after_hs_u1", ya, ZEROIZE ? '0 : last1);
      if (hs2) chk("after_hs_u2", yb, ZEROIZE ? '0 : last2);
      if (v1 && !pv1) begin
        if (q1.size() == 0) chk("unexpected_valid_u1", 320'(v1), 320'(0));
        else begin
          e = q1.pop_front();
          chk("latency_u1", 320'(cyc - e.t), 320'(e.lat));
          chk("data_u1", ya, e.s);
          last1 = e.s;
        end
      end
      if (v2 && !pv2) begin
        if (q2.size() == 0) chk("unexpected_valid_u2", 320'(v2), 320'(0));
        else begin
          e = q2.pop_front();
          chk("latency_u2", 320'(cyc - e.t), 320'(e.lat));
          chk("data_u2", yb, e.s);
          last2 = e.s;
        end
      end
    end
    pv1 = v1;
    pv2 = v2;
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!(r1 && r2)) begin
      if (n == 300) begin
        chk("ready_timeout", 320'(r1 && r2), 320'(1));
        return;
      end
      if (rbp) out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic [3:0] r, input logic [319:0] s);
    logic [319:0] m;
    bit leg;
    wait_ready();
    start_i = 1'b1;
    rounds_i = r;
    {x0_i, x1_i, x2_i, x3_i, x4_i} = s;
    leg = r == 4'd6 || r == 4'd8 || r == 4'd12;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    if (leg) begin
      m = model(s, int'(r));
      q1.push_back('{s: m, t: cyc, lat: int'(r)});
      q2.push_back('{s: m, t: cyc, lat: int'(r) / 2});
      chk("busy_after_accept", 320'({bs1, bs2, r1, r2}), 320'(4'b1100));
    end else begin
      chk("err_pulse", 320'({e1, e2, r1, r2}), 320'(4'b1111));
      @(negedge clk);
      chk("err_single_cycle", 320'({e1, e2, r1, r2}), 320'(4'b0011));
    end
  endtask

  initial begin
    logic [319:0] s, m;
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 320'({r1, bs1, e1, v1, r2, bs2, e2, v2}), 320'(8'b1000_1000));
    chk("reset_state_u1", ya, '0);
    chk("reset_state_u2", yb, '0);
    rst = 1'b0;

    issue(4'd12, {64'h80400c0600000000, 256'd0});
    for (int i = 0; i < 4; i++) begin
      issue(4'd6, rnd_state());
      issue(4'd8, rnd_state());
    end

    // Backpressure: hold the result in DONE, poke start_i, then release.
    wait_ready();
    out_ready_i = 1'b0;
    s = rnd_state();
    m = model(s, 12);
    issue(4'd12, s);
    n = 0;
    while (!v1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_timeout", 320'(v1), 320'(1));
    repeat (5) begin
      start_i = 1'b1;
      rounds_i = 4'd8;
      @(negedge clk);
      chk("bp_ctrl", 320'({v1, v2, r1, r2, bs1, bs2}), 320'(6'b110000));
      chk("bp_hold_u1", ya, m);
      chk("bp_hold_u2", yb, m);
    end
    start_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_back", 320'({r1, r2, v1, v2}), 320'(4'b1100));

    // Reset in the middle of a run.
    issue(4'd12, rnd_state());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q1.delete();
    q2.delete();
    rst = 1'b0;
    chk("midrun_reset_ctrl", 320'({r1, bs1, e1, v1, r2, bs2, e2, v2}), 320'(8'b1000_1000));
    chk("midrun_reset_u1", ya, '0);
    chk("midrun_reset_u2", yb, '0);

    issue(4'd7, rnd_state());
    chk("illegal_no_load_u1", ya, '0);
    chk("illegal_no_load_u2", yb, '0);
    issue(4'd12, rnd_state());

    // Random traffic with random output backpressure and occasional illegal counts.
    rbp = 1'b1;
    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(0, 9);
      issue(n == 0 ? 4'($urandom_range(0, 15)) : (n < 4 ? 4'd6 : (n < 7 ? 4'd8 : 4'd12)),
            rnd_state());
    end
    rbp = 1'b0;
    out_ready_i = 1'b1;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 320'(q1.size() + q2.size()), 320'(0));
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
